alu_sched: RTL and testbench

- Round-robin scheduler that shares the single ALU math engine between NREQ independent requesters.
- Accepts one op/arg command at a time and serialises it onto the ALU byte interface: control byte, then argument byte.
- Waits for the ALU ready pulse, then routes the 32-bit result back to the requester that issued the command.
- Guards against a hung ALU with a timeout that returns an error response.

---
 rtl/alu_sched_if.sv | 28 ++
 rtl/alu_sched.sv | 152 +++++++++++++++
 tb/tb_alu_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// Requester/ALU-side signal bundle for the shared ALU scheduler.
// The master modport is the environment (requesters plus ALU); slave is the scheduler.
interface alu_sched_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0]   req_val;
    logic [8*NREQ-1:0] req_op;
    logic [8*NREQ-1:0] req_arg;
    logic [NREQ-1:0]   req_gnt;
    logic [NREQ-1:0]   rsp_val;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              alu_ctl;
    logic [7:0]        alu_dat;
    logic              alu_ready;
    logic [31:0]       alu_result;

    modport master (
        output req_val, req_op, req_arg, alu_ready, alu_result,
        input  req_gnt, rsp_val, rsp_data, rsp_err, busy, alu_ctl, alu_dat
    );

    modport slave (
        input  req_val, req_op, req_arg, alu_ready, alu_result,
        output req_gnt, rsp_val, rsp_data, rsp_err, busy, alu_ctl, alu_dat
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one byte-serial ALU between NREQ requesters.
// Each command is sent as a control byte then an argument byte; the 32-bit
// result (or a timeout error) is returned to the issuing requester.
module alu_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic       clk,
    input logic       rst_n,
    alu_sched_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StOp,
        StArg,
        StWait,
        StRsp
    } state_e;

    state_e          r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_arg;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_req_gnt;
    logic [NREQ-1:0] r_rsp_val;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_err;
    logic            r_busy;
    logic            r_alu_ctl;
    logic [7:0]      r_alu_dat;

    logic            w_sel_found;
    logic [IW-1:0]   w_sel_idx;
    logic [IW-1:0]   w_cand;
    int unsigned     w_sum;
    logic [7:0]      w_sel_op;
    logic [7:0]      w_sel_arg;
    logic [IW-1:0]   w_next_ptr;

    // Pick the first valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        w_sum       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_sum = 32'(r_rr_ptr) + i;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_cand = IW'(w_sum);
            if (!w_sel_found && bus.req_val[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    // Route the selected requester's op/arg bytes.
    always_comb begin
        w_sel_op  = '0;
        w_sel_arg = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == w_sel_idx) begin
                w_sel_op  = bus.req_op[8*i +: 8];
                w_sel_arg = bus.req_arg[8*i +: 8];
            end
        end
    end

    assign w_next_ptr = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

    // Command FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_arg      <= '0;
            r_cnt      <= '0;
            r_req_gnt  <= '0;
            r_rsp_val  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_alu_ctl  <= 1'b0;
            r_alu_dat  <= '0;
        end else begin
            r_req_gnt <= '0;
            r_rsp_val <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_sel_found) begin
                        r_idx     <= w_sel_idx;
                        r_arg     <= w_sel_arg;
                        r_alu_ctl <= 1'b1;
                        r_alu_dat <= w_sel_op;
                        r_req_gnt <= NREQ'(1) << w_sel_idx;
                        r_busy    <= 1'b1;
                        r_state   <= StOp;
                    end
                end
                StOp: begin
                    r_alu_ctl <= 1'b0;
                    r_alu_dat <= r_arg;
                    r_state   <= StArg;
                end
                StArg: begin
                    r_alu_dat <= '0;
                    r_cnt     <= '0;
                    r_state   <= StWait;
                end
                StWait: begin
                    // A ready arriving on the last timeout cycle still wins.
                    if (bus.alu_ready) begin
                        r_rsp_data <= bus.alu_result;
                        r_rsp_err  <= 1'b0;
                        r_rsp_val  <= NREQ'(1) << r_idx;
                        r_state    <= StRsp;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_rsp_val  <= NREQ'(1) << r_idx;
                        r_state    <= StRsp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRsp: begin
                    r_rr_ptr <= w_next_ptr;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_gnt  = r_req_gnt;
    assign bus.rsp_val  = r_rsp_val;
    assign bus.rsp_data = r_rsp_data;
    assign bus.rsp_err  = r_rsp_err;
    assign bus.busy     = r_busy;
    assign bus.alu_ctl  = r_alu_ctl;
    assign bus.alu_dat  = r_alu_dat;
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed and randomized commands against a transaction-level model.
module tb_alu_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   model_rr;
    logic [31:0] last_data;

    alu_sched_if #(.NREQ(NREQ)) bus ();

    alu_sched #(
        .NREQ   (NREQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Round-robin rule: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    // One complete command; DUT must be idle. delay = WAIT cycle of the ready pulse, -1 = never.
    task automatic do_txn(input logic [3:0] vals, input logic [31:0] ops, input logic [31:0] args,
                          input int delay, input logic [31:0] result, input bit stray_arg);
        int idx;
        int done_w;
        bit to;
        logic [3:0] onehot;
        idx    = pick(vals, model_rr);
        onehot = 4'b0001 << idx;
        to     = !(delay >= 0 && delay < TIMEOUT);
        done_w = to ? TIMEOUT - 1 : delay;
        bus.req_val = vals;
        bus.req_op  = ops;
        bus.req_arg = args;
        step();
        chk("gnt", 32'(bus.req_gnt), 32'(onehot));
        chk("op_ctl", 32'(bus.alu_ctl), 32'd1);
        chk("op_dat", 32'(bus.alu_dat), 32'(ops[8*idx +: 8]));
        chk("op_busy", 32'(bus.busy), 32'd1);
        // Later changes to op/arg must not affect the command in flight.
        bus.req_op  = $urandom();
        bus.req_arg = $urandom();
        step();
        chk("arg_gnt", 32'(bus.req_gnt), 32'd0);
        chk("arg_ctl", 32'(bus.alu_ctl), 32'd0);
        chk("arg_dat", 32'(bus.alu_dat), 32'(args[8*idx +: 8]));
        if (stray_arg) begin
            bus.alu_ready  = 1'b1;
            bus.alu_result = $urandom();
        end
        step();
        bus.alu_ready = 1'b0;
        chk("wait_dat", 32'(bus.alu_dat), 32'd0);
        chk("wait_gnt", 32'(bus.req_gnt), 32'd0);
        for (int w = 0; w <= done_w; w++) begin
            if (w == delay) begin
                bus.alu_ready  = 1'b1;
                bus.alu_result = result;
            end
            step();
            bus.alu_ready = 1'b0;
            if (w < done_w) chk("wait_rsp_val", 32'(bus.rsp_val), 32'd0);
        end
        last_data = to ? 32'd0 : result;
        chk("rsp_val", 32'(bus.rsp_val), 32'(onehot));
        chk("rsp_data", bus.rsp_data, last_data);
        chk("rsp_err", 32'(bus.rsp_err), 32'(to));
        chk("rsp_busy", 32'(bus.busy), 32'd1);
        model_rr = (idx + 1) % NREQ;
        bus.req_val = '0;
        step();
        chk("idle_rsp_val", 32'(bus.rsp_val), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_hold", bus.rsp_data, last_data);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.req_gnt), 32'd0);
        chk({tag, "_rsp_val"}, 32'(bus.rsp_val), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_ctl"}, 32'(bus.alu_ctl), 32'd0);
        chk({tag, "_dat"}, 32'(bus.alu_dat), 32'd0);
    endtask

    initial begin
        logic [3:0] v;
        int r;
        int d;
        clk            = 1'b0;
        rst_n          = 1'b0;
        checks         = 0;
        errors         = 0;
        model_rr       = 0;
        last_data      = '0;
        bus.req_val    = '0;
        bus.req_op     = '0;
        bus.req_arg    = '0;
        bus.alu_ready  = 1'b0;
        bus.alu_result = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single command: op 0x03, arg 0x05, result 8.
        do_txn(4'b0001, ($urandom() & 32'hFFFF_FF00) | 32'h03,
               ($urandom() & 32'hFFFF_FF00) | 32'h05, 1, 32'h0000_0008, 1'b0);

        // Round-robin with all requesters held.
        for (int n = 0; n < 8; n++) begin
            do_txn(4'b1111, $urandom(), $urandom(), 0, $urandom(), 1'b0);
        end

        // Stray ready while idle.
        bus.alu_ready  = 1'b1;
        bus.alu_result = 32'hCAFE_F00D;
        step();
        bus.alu_ready = 1'b0;
        chk("stray_idle_rsp", 32'(bus.rsp_val), 32'd0);
        chk("stray_idle_busy", 32'(bus.busy), 32'd0);
        step();
        chk("stray_idle_rsp2", 32'(bus.rsp_val), 32'd0);

        // Timeout, then a normal command to the same requester.
        do_txn(4'b0100, $urandom(), $urandom(), -1, 32'h1234_5678, 1'b0);
        do_txn(4'b0100, $urandom(), $urandom(), 2, 32'h0BAD_CAFE, 1'b0);

        // Ready coinciding with the last timeout cycle.
        do_txn(4'b1000, $urandom(), $urandom(), TIMEOUT - 1, 32'hDEAD_BEEF, 1'b0);

        // Stray ready during ARG, then a legitimate ready.
        do_txn(4'b0010, $urandom(), $urandom(), 3, 32'h5555_AAAA, 1'b1);

        // Randomized commands.
        for (int n = 0; n < 24; n++) begin
            v = 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            d = (r == 9) ? -1 : int'($urandom_range(0, 6));
            do_txn(v, $urandom(), $urandom(), d, $urandom(), 1'($urandom_range(0, 1)));
        end

        // Leave the pointer at 1 so the post-reset grant proves it cleared.
        do_txn(4'b0001, $urandom(), $urandom(), 0, 32'h7777_0001, 1'b0);

        // Reset during WAIT.
        bus.req_val = 4'b0100;
        step();
        bus.req_val = '0;
        step();
        step();
        step();
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_rr  = 0;
        last_data = '0;
        bus.alu_ready  = 1'b1;
        bus.alu_result = 32'h9999_9999;
        step();
        bus.alu_ready = 1'b0;
        chk("post_reset_rsp", 32'(bus.rsp_val), 32'd0);
        step();
        chk("post_reset_rsp2", 32'(bus.rsp_val), 32'd0);
        chk("post_reset_data", bus.rsp_data, 32'd0);
        do_txn(4'b1111, $urandom(), $urandom(), 1, 32'h0101_0101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
